// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/response handshake bundle between the ALU sequencer and its client
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_c;
    logic       req_d;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_res;
    logic [3:0] resp_flags;
    logic [3:0] resp_upd;

    // Client side: issues operations and drains results.
    modport master (
        output req_valid, req_op, req_a, req_b, req_c, req_d, resp_ready,
        input  req_ready, resp_valid, resp_res, resp_flags, resp_upd
    );

    // Sequencer side: accepts operations and presents results.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_c, req_d, resp_ready,
        output req_ready, resp_valid, resp_res, resp_flags, resp_upd
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives the 8-bit 6502 ALU for one operation and returns result/flags; DECIMAL_EN adds the BCD adjust pass
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        bus,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_i_addc,
    output logic                  alu_daa,
    output logic                  alu_sums,
    output logic                  alu_ands,
    output logic                  alu_ors,
    output logic                  alu_eors,
    output logic                  alu_srs,
    input  logic [7:0]            alu_out,
    input  logic                  alu_acr,
    input  logic                  alu_hc,
    input  logic                  alu_avr
);

    // The ALU it drives is hard-wired 8-bit; any other width is a build mistake.
    generate
        if (WIDTH != 8) begin : g_width_check
            $error("alu_sequencer: WIDTH must be 8");
        end
    endgenerate

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_ROL = 4'd6;
    localparam logic [3:0] OP_LSR = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
`ifdef DECIMAL_EN
        S_ADJ  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] op_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       c_q;
    logic       resp_valid_q;
    logic [7:0] resp_res_q;
    logic [3:0] resp_flags_q;
    logic [3:0] resp_upd_q;

`ifdef DECIMAL_EN
    logic       d_q;
    logic [7:0] res_q;
    logic       c1_q;
    logic       h1_q;
    logic       v1_q;
    logic       go_adj;
    logic [7:0] adj_val;
`else
    logic       unused_inputs;
    assign unused_inputs = alu_hc ^ bus.req_d;
`endif

    logic       op_valid;
    logic       uses_cv;
    logic [7:0] exec_res;
    logic [3:0] exec_flags;

    // Which flags the writeback logic should update for a given op.
    function automatic logic [3:0] upd_mask(input logic [3:0] op);
        case (op)
            OP_ADC, OP_SBC:                         upd_mask = 4'b1111;
            OP_AND, OP_ORA, OP_EOR:                 upd_mask = 4'b1010;
            OP_ASL, OP_ROL, OP_LSR, OP_ROR, OP_CMP: upd_mask = 4'b1011;
            default:                                upd_mask = 4'b0000;
        endcase
    endfunction

    assign op_valid = (op_q <= OP_CMP);
    // Carry/overflow only mean something for adder and shifter ops.
    assign uses_cv  = op_valid && !(op_q == OP_AND || op_q == OP_ORA || op_q == OP_EOR);

    // Invalid ops pass operand A through untouched instead of whatever the idle ALU outputs.
    assign exec_res   = op_valid ? alu_out : a_q;
    assign exec_flags = {exec_res[7], uses_cv & alu_avr, (exec_res == 8'h00), uses_cv & alu_acr};

`ifdef DECIMAL_EN
    assign go_adj = (op_q == OP_ADC || op_q == OP_SBC) && d_q;

    // BCD correction term added to the first-pass result during the adjust pass.
    always_comb begin
        adj_val = 8'h00;
        if (op_q == OP_ADC) begin
            adj_val = (h1_q ? 8'h06 : 8'h00) + (c1_q ? 8'h60 : 8'h00)
                    - ((h1_q && (res_q[3:0] >= 4'hA)) ? 8'h10 : 8'h00);
        end else begin
            adj_val = 8'h00 - ((c1_q ? 8'h00 : 8'h60) + (h1_q ? 8'h00 : 8'h06));
        end
    end
`endif

    // ALU operand and function selects, decoded from the current state and latched op.
    always_comb begin
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_i_addc = 1'b0;
        alu_daa    = 1'b0;
        alu_sums   = 1'b0;
        alu_ands   = 1'b0;
        alu_ors    = 1'b0;
        alu_eors   = 1'b0;
        alu_srs    = 1'b0;
        case (state)
            S_EXEC: begin
                case (op_q)
                    OP_ADC: begin
                        alu_sums   = 1'b1;
                        alu_a      = a_q;
                        alu_b      = b_q;
                        alu_i_addc = c_q;
`ifdef DECIMAL_EN
                        alu_daa    = d_q;
`endif
                    end
                    OP_SBC: begin
                        alu_sums   = 1'b1;
                        alu_a      = a_q;
                        alu_b      = ~b_q;
                        alu_i_addc = c_q;
                    end
                    OP_AND: begin
                        alu_ands = 1'b1;
                        alu_a    = a_q;
                        alu_b    = b_q;
                    end
                    OP_ORA: begin
                        alu_ors = 1'b1;
                        alu_a   = a_q;
                        alu_b   = b_q;
                    end
                    OP_EOR: begin
                        alu_eors = 1'b1;
                        alu_a    = a_q;
                        alu_b    = b_q;
                    end
                    OP_ASL: begin
                        alu_sums = 1'b1;
                        alu_a    = a_q;
                        alu_b    = a_q;
                    end
                    OP_ROL: begin
                        alu_sums   = 1'b1;
                        alu_a      = a_q;
                        alu_b      = a_q;
                        alu_i_addc = c_q;
                    end
                    OP_LSR: begin
                        alu_srs = 1'b1;
                        alu_a   = a_q;
                    end
                    OP_ROR: begin
                        alu_srs    = 1'b1;
                        alu_a      = a_q;
                        alu_i_addc = c_q;
                    end
                    OP_CMP: begin
                        alu_sums   = 1'b1;
                        alu_a      = a_q;
                        alu_b      = ~b_q;
                        alu_i_addc = 1'b1;
                    end
                    default: ;
                endcase
            end
`ifdef DECIMAL_EN
            S_ADJ: begin
                alu_sums = 1'b1;
                alu_a    = res_q;
                alu_b    = adj_val;
            end
`endif
            default: ;
        endcase
    end

    // Operation sequencer: accept, run the ALU pass(es), hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            op_q         <= 4'h0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            c_q          <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_res_q   <= 8'h00;
            resp_flags_q <= 4'h0;
            resp_upd_q   <= 4'h0;
`ifdef DECIMAL_EN
            d_q          <= 1'b0;
            res_q        <= 8'h00;
            c1_q         <= 1'b0;
            h1_q         <= 1'b0;
            v1_q         <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        c_q   <= bus.req_c;
`ifdef DECIMAL_EN
                        d_q   <= bus.req_d;
`endif
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_res_q   <= exec_res;
                    resp_flags_q <= exec_flags;
                    resp_upd_q   <= upd_mask(op_q);
                    resp_valid_q <= 1'b1;
                    state        <= S_DONE;
`ifdef DECIMAL_EN
                    res_q <= exec_res;
                    c1_q  <= alu_acr;
                    h1_q  <= alu_hc;
                    v1_q  <= alu_avr;
                    // Decimal add/sub needs the correction pass before anything is reported.
                    if (go_adj) begin
                        resp_valid_q <= 1'b0;
                        state        <= S_ADJ;
                    end
`endif
                end
`ifdef DECIMAL_EN
                S_ADJ: begin
                    res_q        <= alu_out;
                    resp_res_q   <= alu_out;
                    resp_flags_q <= {alu_out[7], v1_q, (alu_out == 8'h00), c1_q};
                    resp_upd_q   <= 4'b1111;
                    resp_valid_q <= 1'b1;
                    state        <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_res   = resp_res_q;
    assign bus.resp_flags = resp_flags_q;
    assign bus.resp_upd   = resp_upd_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with a behavioural 6502 ALU
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] alu_a, alu_b, alu_out;
    logic       alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs;
    logic       alu_acr, alu_hc, alu_avr;
    logic [10:0] junk = 11'h0;
    logic [4:0] lo, hi;
    logic       hcd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sequencer_if bus();

    alu_sequencer #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_i_addc (alu_i_addc),
        .alu_daa    (alu_daa),
        .alu_sums   (alu_sums),
        .alu_ands   (alu_ands),
        .alu_ors    (alu_ors),
        .alu_eors   (alu_eors),
        .alu_srs    (alu_srs),
        .alu_out    (alu_out),
        .alu_acr    (alu_acr),
        .alu_hc     (alu_hc),
        .alu_avr    (alu_avr)
    );

    // Garbage the ALU shows when no function (or a logic function) is selected.
    always @(negedge clk) junk <= 11'($urandom);

    // Behavioural 6502 ALU: nibble adder with decimal carries, logic unit, right shifter.
    always_comb begin
        lo  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0000, alu_i_addc};
        hcd = alu_daa ? (lo > 5'd9) : lo[4];
        hi  = {1'b0, alu_a[7:4]} + {1'b0, alu_b[7:4]} + {4'b0000, hcd};
        alu_out = junk[7:0];
        alu_acr = junk[8];
        alu_hc  = junk[9];
        alu_avr = junk[10];
        if (alu_sums) begin
            alu_out = {hi[3:0], lo[3:0]};
            alu_hc  = hcd;
            alu_acr = alu_daa ? (hi > 5'd9) : hi[4];
            alu_avr = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
        end else if (alu_ands) begin
            alu_out = alu_a & alu_b;
        end else if (alu_ors) begin
            alu_out = alu_a | alu_b;
        end else if (alu_eors) begin
            alu_out = alu_a ^ alu_b;
        end else if (alu_srs) begin
            alu_out = {alu_i_addc, alu_a[7:1]};
            alu_acr = alu_a[0];
            alu_hc  = 1'b0;
            alu_avr = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] flags;
        logic [3:0] upd;
        logic       dec;
    } exp_t;

    function automatic int bcd2i(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [7:0] rand_bcd();
        return i2bcd($urandom_range(0, 99));
    endfunction

    // Architectural meaning of each op, computed with plain integer and BCD arithmetic.
    function automatic exp_t ref_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input logic c, input logic d);
        exp_t e;
        int s;
        logic [7:0] r, nb, inter;
        logic cf, vf;
        int l4, h4;
        e.dec = 1'b0;
        r = a; cf = 1'b0; vf = 1'b0;
        nb = ~b;
        case (op)
            4'd0: begin
                s = int'(a) + int'(b) + int'(c);
                r = 8'(s); cf = (s > 255);
                vf = (a[7] == b[7]) && (r[7] != a[7]);
`ifdef DECIMAL_EN
                if (d) begin
                    e.dec = 1'b1;
                    s = bcd2i(a) + bcd2i(b) + int'(c);
                    cf = (s > 99);
                    r = i2bcd(s % 100);
                    l4 = int'(a[3:0]) + int'(b[3:0]) + int'(c);
                    h4 = int'(a[7:4]) + int'(b[7:4]) + ((l4 > 9) ? 1 : 0);
                    inter = {4'(h4), 4'(l4)};
                    vf = (a[7] == b[7]) && (inter[7] != a[7]);
                end
`endif
            end
            4'd1: begin
                s = int'(a) + int'(nb) + int'(c);
                r = 8'(s); cf = (s > 255);
                vf = (a[7] == nb[7]) && (r[7] != a[7]);
`ifdef DECIMAL_EN
                if (d) begin
                    e.dec = 1'b1;
                    s = bcd2i(a) - bcd2i(b) - (1 - int'(c));
                    cf = (s >= 0);
                    r = i2bcd((s + 100) % 100);
                end
`endif
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = {a[6:0], 1'b0}; cf = a[7]; vf = a[7] ^ a[6]; end
            4'd6: begin r = {a[6:0], c};    cf = a[7]; vf = a[7] ^ a[6]; end
            4'd7: begin r = {1'b0, a[7:1]}; cf = a[0]; end
            4'd8: begin r = {c, a[7:1]};    cf = a[0]; end
            4'd9: begin
                s = int'(a) + int'(nb) + 1;
                r = 8'(s); cf = (s > 255);
                vf = (a[7] == nb[7]) && (r[7] != a[7]);
            end
            default: r = a;
        endcase
        e.res   = r;
        e.flags = {r[7], vf, (r == 8'h00), cf};
        if (op <= 4'd1)      e.upd = 4'b1111;
        else if (op <= 4'd4) e.upd = 4'b1010;
        else if (op <= 4'd9) e.upd = 4'b1011;
        else                 e.upd = 4'b0000;
        return e;
    endfunction

    // ALU function each op is supposed to use: {sums, ands, ors, eors, srs}.
    function automatic logic [4:0] exp_sel(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd5, 4'd6, 4'd9: return 5'b10000;
            4'd2:                         return 5'b01000;
            4'd3:                         return 5'b00100;
            4'd4:                         return 5'b00010;
            4'd7, 4'd8:                   return 5'b00001;
            default:                      return 5'b00000;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic d);
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_d = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic d, input int stall,
                          input bit chk_adj, input logic [7:0] exp_adj);
        exp_t e;
        int n;
        e = ref_model(op, a, b, c, d);
        issue(op, a, b, c, d);
        check("exec_sel", {alu_sums, alu_ands, alu_ors, alu_eors, alu_srs}, exp_sel(op));
        check("exec_daa", alu_daa, (op == 4'd0) && e.dec);
        if (op <= 4'd9) check("exec_alu_a", alu_a, a);
        check("req_ready_busy", bus.req_ready, 0);
        n = 0;
        while (!bus.resp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
            if (chk_adj && n == 1) check("adj_alu_b", alu_b, exp_adj);
        end
        check("resp_timeout", bus.resp_valid, 1);
        check("latency", n, e.dec ? 2 : 1);
        check("resp_res", bus.resp_res, e.res);
        check("resp_flags", bus.resp_flags, e.flags);
        check("resp_upd", bus.resp_upd, e.upd);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_hold", {bus.resp_valid, bus.resp_res, bus.resp_flags, bus.resp_upd},
                  {1'b1, e.res, e.flags, e.upd});
            check("stall_req_ready", bus.req_ready, 0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("resp_drop", bus.resp_valid, 0);
        check("back_to_idle", bus.req_ready, 1);
    endtask

    task automatic reset_mid(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic d, input bit in_adj);
        issue(op, a, b, c, d);
        if (in_adj) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_resp", {bus.resp_valid, bus.resp_res, bus.resp_flags, bus.resp_upd}, 0);
        check("rst_alu", {alu_a, alu_b, alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors,
                          alu_eors, alu_srs}, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_no_resp", bus.resp_valid, 0);
            check("rst_req_ready", bus.req_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [7:0] a, b;
        logic c, d;
        bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_a = 8'h00; bus.req_b = 8'h00;
        bus.req_c = 1'b0; bus.req_d = 1'b0; bus.resp_ready = 1'b0;
        #1;
        check("reset_resp", {bus.resp_valid, bus.resp_res, bus.resp_flags, bus.resp_upd}, 0);
        check("reset_alu", {alu_a, alu_b, alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors,
                            alu_eors, alu_srs}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_req_ready", bus.req_ready, 1);

        run_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd9, 8'h40, 8'h40, 1'b0, 1'b0, 3, 1'b0, 8'h00);
        run_op(4'd7, 8'h81, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd5, 8'h80, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd6, 8'h40, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00);
        run_op(4'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 8'h00);
        run_op(4'd13, 8'h00, 8'h55, 1'b1, 1'b1, 0, 1'b0, 8'h00);
`ifdef DECIMAL_EN
        run_op(4'd0, 8'h19, 8'h28, 1'b0, 1'b1, 0, 1'b0, 8'h00);
        run_op(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 2, 1'b1, 8'h56);
        run_op(4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 0, 1'b1, 8'hFA);
        reset_mid(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 1'b1);
`else
        run_op(4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 0, 1'b0, 8'h00);
        run_op(4'd1, 8'h10, 8'h01, 1'b1, 1'b1, 0, 1'b0, 8'h00);
`endif
        reset_mid(4'd1, 8'h33, 8'h11, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 12));
            if (op >= 4'd10) op = 4'($urandom_range(10, 15));
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            d = 1'($urandom);
            if (op <= 4'd1 && d) begin
                a = rand_bcd();
                b = rand_bcd();
            end
            run_op(op, a, b, c, d, $urandom_range(0, 3), 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Sequential controller that drives the 8-bit 6502 ALU's operation selects and carry-in, then captures its result and flags.
- Accepts one ALU operation at a time over a valid/ready request port.
- Runs one ALU pass for binary ops, and a second adjust pass for decimal ADC/SBC.
- Returns the result, N/V/Z/C and a flag-update mask over a valid/ready response port, for the status-register and accumulator writeback logic.

Parameters:
- WIDTH, 8, datapath width; must equal 8 (ALU is fixed 8-bit); elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 ASL, 6 ROL, 7 LSR, 8 ROR, 9 CMP, 10-15 invalid
- req_a  in  8  operand A (accumulator/memory)
- req_b  in  8  operand B
- req_c  in  1  carry flag in
- req_d  in  1  decimal flag in
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_res  out  8  result
- resp_flags  out  4  {N,V,Z,C}
- resp_upd  out  4  {N,V,Z,C} write-enable mask
- alu_a, alu_b  out  8 each  ALU operands
- alu_i_addc, alu_daa, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs  out  1 each  ALU controls
- alu_out  in  8  ALU result
- alu_acr, alu_hc, alu_avr  in  1 each  ALU carry, half carry, overflow

Behaviour:
- Reset: state IDLE; all registers 0; resp_valid=0, resp_res=0, resp_flags=0, resp_upd=0.
- Reset mid-operation aborts the operation with no response.
- States: IDLE -> EXEC -> (ADJ) -> DONE -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op/a/b/c/d and go to EXEC.
- ALU control outputs are combinational from state and latched op.
  - In IDLE and DONE: all selects, i_addc and daa are 0; alu_a and alu_b are 0.
- EXEC, one cycle; ALU drive per op:
  - ADC: sums, a, b, i_addc=c, daa=d.
  - SBC: sums, a, ~b, i_addc=c, daa=0.
  - AND/ORA/EOR: ands/ors/eors respectively.
  - ASL: sums, a, a, i_addc=0.
  - ROL: sums, a, a, i_addc=c.
  - LSR: srs, i_addc=0.
  - ROR: srs, i_addc=c.
  - CMP: sums, a, ~b, i_addc=1.
  - Invalid: no select asserted; result forced to a.
- End of EXEC: register res=alu_out, c1=alu_acr, h1=alu_hc, v1=alu_avr.
  - Next state is ADJ if (ADC||SBC)&&d, else DONE.
- ADJ, one cycle: sums, alu_a=res, i_addc=0, daa=0, alu_b=adj (mod 256).
  - ADC: adj = (h1?0x06:0) + (c1?0x60:0) - ((h1&&res[3:0]>=0xA)?0x10:0).
  - SBC: adj = -((c1?0:0x60) + (h1?0:0x06)).
  - End of ADJ: res=alu_out; ADJ-pass carry is discarded.
- Flags:
  - N = res[7] and Z = (res==0), taken from the final result.
  - C = c1 (the EXEC-pass alu_acr for sums and srs ops).
  - V = v1.
  - For logic ops and invalid ops, C and V report 0.
- resp_upd masks:
  - ADC/SBC: 1111.
  - AND/ORA/EOR: 1010.
  - Shifts and CMP: 1011.
  - Invalid: 0000.
- DONE:
  - resp_valid=1, with resp_* stable until resp_ready.
  - On resp_valid&&resp_ready, go to IDLE and deassert resp_valid.
  - No new accept in the same cycle.
- Latency:
  - Accept at edge k: EXEC in cycle k+1, resp_valid from cycle k+2.
  - Decimal ADC/SBC: resp_valid from cycle k+3.
- Throughput: one op per 3 cycles minimum (binary), 4 (decimal).

Optional Feature:
- DECIMAL_EN defined: ADJ state present; decimal behaviour as above.
- DECIMAL_EN undefined:
  - ADJ state absent; req_d ignored.
  - alu_daa tied 0.
  - ADC/SBC are always binary with 2-cycle latency.

Test Plan:
- ADC a=0x50 b=0x50 c=0 d=0 -> res 0xA0, flags N1 V1 Z0 C0, upd 1111; resp_valid at k+2.
- SBC a=0x00 b=0x01 c=1 -> res 0xFF, N1 V0 Z0 C0. CMP a=0x40 b=0x40 -> res 0x00, Z1 C1 N0, upd 1011.
- DECIMAL_EN, decimal ADC (d=1):
  - 0x19+0x28 c=0 -> 0x47, C0.
  - 0x99+0x01 c=0 -> 0x00, C1, Z1.
  - resp_valid at k+3; alu_b=0x56 during ADJ for the 0x99+0x01 case.
- DECIMAL_EN, decimal SBC: 0x10-0x01 c=1 d=1 -> alu_b=0xFA in ADJ, res 0x09, C1.
- Shifts:
  - LSR 0x81 -> 0x40, C1.
  - ROR 0x01 c=1 -> 0x80, N1 C1.
  - ASL 0x80 -> 0x00, Z1 C1.
  - ROL 0x40 c=1 -> 0x81, N1 C0.
- Handshake and reset:
  - resp_ready held low 3 cycles -> resp_* stable, req_ready=0.
  - rst_n pulsed low during EXEC/ADJ -> all outputs 0 immediately, no response, req_ready=1 after release.
